flop_arb: RTL and testbench

Round-robin arbiter and write sequencer that shares one W-bit register between four requesters. Each requester raises `req`, gets a one-hot grant and presents its data. The controller loads the data into the shared register and returns a one-cycle acknowledge. It sits in front of the team's plain D-register and owns that register's load enable and synchronous clear.

---
 rtl/flop_arb.sv | 104 ++++++++++
 tb/tb_flop_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flop_arb.sv
// Round-robin arbiter sharing one W-bit register among four requesters; loads owner data, pulses ack.
// Latency: grant one edge after req seen in IDLE, data lands on the next edge, ack for one cycle after.
// Backpressure: none; a requester holds req until acked, dropping it during GRANT aborts the write.
module flop_arb #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic            c,
  input  logic            r,
  input  logic [3:0]      req,
  input  logic [4*W-1:0]  d,
  input  logic            clr,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic [W-1:0]    q,
  output logic            busy,
  output logic [CW-1:0]   cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    owner, owner_nx;
  logic [W-1:0]  q_nx;
  logic [CW-1:0] cnt_nx;
  logic [1:0]    win;
  logic          win_vld;
  logic [1:0]    idx;

  // Pick the first requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic; clr always wins over any load of q.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    q_nx     = q;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          owner_nx = win;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          // Owner withdrew: nothing lands, pointer stays so it keeps its turn.
          state_nx = IDLE;
        end else if (clr) begin
          // Write is swallowed by the clear but the turn is still consumed.
          ptr_nx   = owner + 2'd1;
          state_nx = IDLE;
        end else begin
          q_nx     = d[owner*W +: W];
          state_nx = WRITE;
        end
      end
      WRITE: begin
        ptr_nx   = owner + 2'd1;
        cnt_nx   = cnt + CW'(1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clr) q_nx = '0;
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      q     <= q_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs decoded from registered state so reset clears them immediately.
  assign busy = (state != IDLE);
  assign gnt  = busy ? (4'b0001 << owner) : 4'b0000;
  assign ack  = (state == WRITE) ? (4'b0001 << owner) : 4'b0000;

endmodule

// File: tb/tb_flop_arb.sv
// Bench for flop_arb: directed scenarios plus randomized traffic against a transaction-phase model.
// Model advances once per rising edge using the inputs present at that edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_flop_arb;

  localparam int W  = 4;
  localparam int CW = 8;

  logic            c = 1'b0;
  logic            r;
  logic [3:0]      req;
  logic [4*W-1:0]  d;
  logic            clr;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic [W-1:0]    q;
  logic            busy;
  logic [CW-1:0]   cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0 = no owner, 1 = owner granted, 2 = owner's write landed.
  int m_phase, m_owner, m_ptr, m_q, m_cnt;

  flop_arb #(.W(W), .CW(CW)) dut (
    .c(c), .r(r), .req(req), .d(d), .clr(clr),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy), .cnt(cnt)
  );

  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_q = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge();
    int found;
    found = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (found == 0 && req[(m_ptr + i) % 4]) begin
          m_owner = (m_ptr + i) % 4;
          found   = 1;
        end
      end
      if (found == 1) m_phase = 1;
    end else if (m_phase == 1) begin
      if (!req[m_owner]) m_phase = 0;
      else if (clr) begin
        m_ptr   = (m_owner + 1) % 4;
        m_phase = 0;
      end else begin
        m_q     = int'(d[m_owner*W +: W]);
        m_phase = 2;
      end
    end else begin
      m_ptr   = (m_owner + 1) % 4;
      m_cnt   = (m_cnt + 1) % 256;
      m_phase = 0;
    end
    if (clr) m_q = 0;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_phase != 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_ack();
    return (m_phase == 2) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge c);
    if (!r) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    r = 1'b0; req = 4'b1111; d = '0; clr = 1'b0;
    model_reset();
    tick(); tick();
    vectors++;
    if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || q !== 4'b0 || cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b ack=%b busy=%b q=%h cnt=%0d required all zero", gnt, ack, busy, q, cnt);
    end
    r = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%b required 0001", gnt);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_write();
    req = 4'b0100; d = '0; d[11:8] = 4'b1100;
    tick();
    vectors++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || ack !== 4'b0) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%b busy=%b ack=%b required 0100 1 0000", gnt, busy, ack);
    end
    tick();
    req = 4'b0000;  // dropping req during WRITE must not cancel the write
    vectors++;
    if (gnt !== 4'b0100 || ack !== 4'b0100 || q !== 4'b1100) begin
      miscompares++;
      $display("FAIL single_write: gnt=%b ack=%b q=%b required 0100 0100 1100", gnt, ack, q);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || cnt !== 8'd1 || q !== 4'b1100) begin
      miscompares++;
      $display("FAIL single_done: gnt=%b ack=%b busy=%b cnt=%0d q=%b required 0000 0000 0 1 1100", gnt, ack, busy, cnt, q);
    end
  endtask

  task automatic test_round_robin();
    int start, base, o;
    logic [W-1:0] dv;
    start = m_ptr;
    base  = $urandom_range(0, 15);
    for (int i = 0; i < 4; i++) begin
      dv = 4'(base ^ i);
      d[i*W +: W] = dv;
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      o = (start + n) % 4;
      tick();
      vectors++;
      if (gnt !== 4'(1 << o)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: gnt=%b required %b", n, gnt, 4'(1 << o));
      end
      tick();
      vectors++;
      if (q !== 4'(base ^ o) || ack !== 4'(1 << o)) begin
        miscompares++;
        $display("FAIL rr_write[%0d]: q=%h ack=%b required %h %b", n, q, ack, 4'(base ^ o), 4'(1 << o));
      end
      tick();
    end
    req = 4'b0000;
    vectors++;
    if (cnt !== 8'(m_cnt) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_count: cnt=%0d busy=%b required %0d 0", cnt, busy, m_cnt);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] q0;
    logic [CW-1:0] c0;
    // A write from requester 0 leaves the pointer at requester 1.
    req = 4'b0001; d[3:0] = 4'h5;
    while (!(m_phase == 0 && m_ptr == 1)) tick();
    req = 4'b0010; d[7:4] = 4'h9;
    q0 = q; c0 = cnt;
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (ack !== 4'b0 || gnt !== 4'b0 || q !== q0 || cnt !== c0) begin
      miscompares++;
      $display("FAIL abort: ack=%b gnt=%b q=%h cnt=%0d required 0000 0000 %h %0d", ack, gnt, q, cnt, q0, c0);
    end
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_ptr_kept: gnt=%b required 0010", gnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_clear();
    logic [CW-1:0] c0;
    req = 4'b1000; d[15:12] = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL clr_setup_grant: gnt=%b required 1000", gnt);
    end
    c0 = cnt;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (q !== 4'b0 || ack !== 4'b0 || gnt !== 4'b0 || cnt !== c0) begin
      miscompares++;
      $display("FAIL clr_on_grant: q=%h ack=%b gnt=%b cnt=%0d required 0 0000 0000 %0d", q, ack, gnt, cnt, c0);
    end
    req = 4'b1111; d[3:0] = 4'b1010;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL clr_ptr_advanced: gnt=%b required 0001", gnt);
    end
    req = 4'b0001;
    tick(); tick();
    req = 4'b0000;
    vectors++;
    if (q !== 4'b1010) begin
      miscompares++;
      $display("FAIL clr_reload: q=%b required 1010", q);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (q !== 4'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_in_idle: q=%b busy=%b required 0000 0", q, busy);
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    req = 4'b0001; d[3:0] = 4'h6;
    while (m_cnt != 255 && guard < 1000) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 1000 || cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_reach_255: cnt=%0d guard=%0d required 255 within 1000 cycles", cnt, guard);
    end
    tick(); tick(); tick();
    vectors++;
    if (cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_to_zero: cnt=%0d required 0", cnt);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0001; d[3:0] = 4'h7;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || q === 4'b0 || cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL areset_setup: gnt=%b q=%h cnt=%0d required 0001 nonzero 1", gnt, q, cnt);
    end
    #2 r = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || q !== 4'b0 || cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL areset_immediate: gnt=%b ack=%b busy=%b q=%h cnt=%0d required all zero", gnt, ack, busy, q, cnt);
    end
    model_reset();
    #1 r = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || ack !== 4'b0) begin
      miscompares++;
      $display("FAIL areset_regrant: gnt=%b ack=%b required 0001 0000", gnt, ack);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      req = 4'($urandom_range(0, 15));
      d   = 16'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if (gnt !== exp_gnt() || ack !== exp_ack() || busy !== (m_phase != 0) ||
          q !== 4'(m_q) || cnt !== 8'(m_cnt)) begin
        miscompares++;
        $display("FAIL random[%0d]: gnt=%b ack=%b busy=%b q=%h cnt=%0d required %b %b %b %h %0d",
                 n, gnt, ack, busy, q, cnt, exp_gnt(), exp_ack(), (m_phase != 0), 4'(m_q), m_cnt);
      end
      vectors++;
      if (!$onehot0(gnt) || !$onehot0(ack)) begin
        miscompares++;
        $display("FAIL random_onehot[%0d]: gnt=%b ack=%b required at most one bit each", n, gnt, ack);
      end
    end
    clr = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_abort();
    test_clear();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
